// File: rtl/mc_ctrl.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/write-back
// and drives datapath enables and mux selects. Define MC_CTRL_IMM_EN for I-type ALU ops.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic [1:0] pc_source,
  output logic [5:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'h0,
    S_DECODE   = 4'h1,
    S_MEM_ADDR = 4'h2,
    S_MEM_RD   = 4'h3,
    S_MEM_WB   = 4'h4,
    S_MEM_WR   = 4'h5,
    S_R_EXEC   = 4'h6,
    S_R_WB     = 4'h7,
    S_BRANCH   = 4'h8,
    S_JUMP     = 4'h9,
    S_I_EXEC   = 4'hA,
    S_I_WB     = 4'hB,
    S_RESET    = 4'hF
  } state_t;

  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_J     = 6'h02;

  state_t cur;
  state_t dec_next;
  logic   dec_ok;

  // Opcode dispatch; anything unrecognised falls back to FETCH and flags illegal
  always_comb begin
    dec_next = S_FETCH;
    dec_ok   = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        if (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27}) begin
          dec_next = S_R_EXEC;
          dec_ok   = 1'b1;
        end
      end
      OPC_LW, OPC_SW: begin
        dec_next = S_MEM_ADDR;
        dec_ok   = 1'b1;
      end
      OPC_BEQ: begin
        dec_next = S_BRANCH;
        dec_ok   = 1'b1;
      end
      OPC_J: begin
        dec_next = S_JUMP;
        dec_ok   = 1'b1;
      end
`ifdef MC_CTRL_IMM_EN
      6'h08, 6'h0C, 6'h0D, 6'h0E: begin
        dec_next = S_I_EXEC;
        dec_ok   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= S_RESET;
    end else begin
      case (cur)
        S_RESET:    cur <= S_FETCH;
        S_FETCH:    if (mem_ready) cur <= S_DECODE;
        S_DECODE:   cur <= dec_next;
        S_MEM_ADDR: cur <= (opcode == OPC_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) cur <= S_MEM_WB;
        S_MEM_WB:   cur <= S_FETCH;
        S_MEM_WR:   if (mem_ready) cur <= S_FETCH;
        S_R_EXEC:   cur <= S_R_WB;
        S_R_WB:     cur <= S_FETCH;
        S_BRANCH:   cur <= S_FETCH;
        S_JUMP:     cur <= S_FETCH;
`ifdef MC_CTRL_IMM_EN
        S_I_EXEC:   cur <= S_I_WB;
        S_I_WB:     cur <= S_FETCH;
`endif
        default:    cur <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the state register; only the memory-completion strobes look at mem_ready
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    imm_zext      = 1'b0;
    pc_source     = 2'b00;
    alu_op        = OP_NOP;
    illegal       = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = OP_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = OP_ADD;
        illegal   = ~dec_ok;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = OP_ADD;
      end
      S_MEM_RD: begin
        mem_read  = 1'b1;
        iord      = 1'b1;
        mdr_write = mem_ready;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = funct;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = OP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
`ifdef MC_CTRL_IMM_EN
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        imm_zext  = (opcode != 6'h08);
        case (opcode)
          6'h08:   alu_op = OP_ADD;
          6'h0C:   alu_op = OP_AND;
          6'h0D:   alu_op = OP_OR;
          6'h0E:   alu_op = OP_XOR;
          default: alu_op = OP_NOP;
        endcase
      end
      S_I_WB: begin
        reg_write = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle comparison against an instruction-level
// trace model, plus literal checks on cycle counts, pulse counts and async reset.
module tb_mc_ctrl;

`ifdef MC_CTRL_IMM_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mdr_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, imm_zext, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [5:0] alu_op;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mdr_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [1:0] pc_source;
    logic [5:0] alu_op;
    logic       illegal;
  } vec_t;

  vec_t exp_q[$];
  int   vectors = 0;
  int   errors = 0;
  int   ir_cnt = 0, mdr_cnt = 0, pwc_cnt = 0, ill_cnt = 0, rw_cnt = 0;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mdr_write(mdr_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_zext(imm_zext), .pc_source(pc_source), .alu_op(alu_op),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  function automatic bit is_legal(logic [5:0] opc, logic [5:0] fn);
    case (opc)
      6'h00:                      return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
      6'h23, 6'h2B, 6'h04, 6'h02: return 1'b1;
      6'h08, 6'h0C, 6'h0D, 6'h0E: return IMM_EN;
      default:                    return 1'b0;
    endcase
  endfunction

  // What the datapath should see in a given step of an instruction
  function automatic vec_t expect_for(int st, logic [5:0] opc, logic [5:0] fn, logic mr);
    vec_t e;
    e = '0;
    e.st = 4'(st);
    case (st)
      0: begin e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_op = 6'h20; e.ir_write = mr; e.pc_write = mr; end
      1: begin e.alu_src_b = 2'b11; e.alu_op = 6'h20; e.illegal = !is_legal(opc, fn); end
      2: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 6'h20; end
      3: begin e.mem_read = 1; e.iord = 1; e.mdr_write = mr; end
      4: begin e.reg_write = 1; e.mem_to_reg = 1; end
      5: begin e.mem_write = 1; e.iord = 1; end
      6: begin e.alu_src_a = 1; e.alu_op = fn; end
      7: begin e.reg_write = 1; e.reg_dst = 1; end
      8: begin e.alu_src_a = 1; e.alu_op = 6'h22; e.pc_write_cond = 1; e.pc_source = 2'b01; end
      9: begin e.pc_write = 1; e.pc_source = 2'b10; end
      10: begin
        e.alu_src_a = 1; e.alu_src_b = 2'b10; e.imm_zext = (opc != 6'h08);
        e.alu_op = (opc == 6'h08) ? 6'h20 : (opc == 6'h0C) ? 6'h24 : (opc == 6'h0D) ? 6'h25 : 6'h26;
      end
      11: e.reg_write = 1;
      default: ;
    endcase
    return e;
  endfunction

  // Single compare process: every driven cycle has exactly one expected vector
  initial begin
    vec_t e, act;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mdr_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, imm_zext, pc_source,
               alu_op, illegal};
        vectors++;
        if (act !== e) begin
          errors++;
          $display("[TB] FAIL cycle_vec t=%0t exp_state=%0d actual=%h required=%h", $time, e.st, act, e);
        end
        ir_cnt  += int'(ir_write);
        mdr_cnt += int'(mdr_write);
        pwc_cnt += int'(pc_write_cond);
        ill_cnt += int'(illegal);
        rw_cnt  += int'(reg_write);
      end
    end
  end

  task automatic check_val(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive_cycle(input logic [5:0] opc, input logic [5:0] fn, input logic mr,
                             input logic rst, input int st);
    @(negedge clk);
    rst_n = rst;
    opcode = opc;
    funct = fn;
    mem_ready = mr;
    exp_q.push_back(expect_for(st, opc, fn, mr));
  endtask

  // Expand one instruction into its per-cycle state trace and drive it
  task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input int fw, input int mw,
                           input logic idle_mr, input bit peek_fetch, output int cycles);
    int   seq[$];
    logic mrs[$];
    for (int i = 0; i < fw; i++) begin seq.push_back(0); mrs.push_back(1'b0); end
    seq.push_back(0); mrs.push_back(1'b1);
    seq.push_back(1); mrs.push_back(idle_mr);
    if (is_legal(opc, fn)) begin
      if (opc == 6'h00) begin
        seq.push_back(6); mrs.push_back(idle_mr); seq.push_back(7); mrs.push_back(idle_mr);
      end else if (opc == 6'h23) begin
        seq.push_back(2); mrs.push_back(idle_mr);
        for (int i = 0; i < mw; i++) begin seq.push_back(3); mrs.push_back(1'b0); end
        seq.push_back(3); mrs.push_back(1'b1);
        seq.push_back(4); mrs.push_back(idle_mr);
      end else if (opc == 6'h2B) begin
        seq.push_back(2); mrs.push_back(idle_mr);
        for (int i = 0; i < mw; i++) begin seq.push_back(5); mrs.push_back(1'b0); end
        seq.push_back(5); mrs.push_back(1'b1);
      end else if (opc == 6'h04) begin
        seq.push_back(8); mrs.push_back(idle_mr);
      end else if (opc == 6'h02) begin
        seq.push_back(9); mrs.push_back(idle_mr);
      end else begin
        seq.push_back(10); mrs.push_back(idle_mr); seq.push_back(11); mrs.push_back(idle_mr);
      end
    end
    for (int i = 0; i < seq.size(); i++) begin
      drive_cycle(opc, fn, mrs[i], 1'b1, seq[i]);
      if (peek_fetch && i == fw) begin
        #3;
        check_val("fetch_ir_write", int'(ir_write), 1);
        check_val("fetch_pc_write", int'(pc_write), 1);
        check_val("fetch_alu_op", int'(alu_op), 32);
      end
    end
    cycles = seq.size();
    #3;
  endtask

  initial begin
    int cyc, base_a, base_b;
    $display("[TB] mc_ctrl bench start, IMM_EN=%0d", IMM_EN);

    // Reset held three cycles, then released; FETCH must follow on the next edge
    for (int i = 0; i < 3; i++) drive_cycle(6'h00, 6'h20, 1'b1, 1'b0, 15);
    drive_cycle(6'h00, 6'h20, 1'b1, 1'b1, 15);

    base_a = pwc_cnt;
    run_instr(6'h00, 6'h20, 0, 0, 1'b1, 1'b1, cyc); check_val("add_cycles", cyc, 4);
    run_instr(6'h2B, 6'h00, 0, 0, 1'b1, 1'b0, cyc); check_val("sw_cycles", cyc, 4);
    run_instr(6'h23, 6'h00, 0, 0, 1'b1, 1'b0, cyc); check_val("lw_cycles", cyc, 5);
    run_instr(6'h04, 6'h00, 0, 0, 1'b1, 1'b0, cyc); check_val("beq_cycles", cyc, 3);
    run_instr(6'h02, 6'h00, 0, 0, 1'b1, 1'b0, cyc); check_val("j_cycles", cyc, 3);
    check_val("pc_write_cond_pulses", pwc_cnt - base_a, 1);

    // Stalled lw, with mem_ready low in every non-memory state to show it is ignored there
    base_a = ir_cnt; base_b = mdr_cnt;
    run_instr(6'h23, 6'h00, 3, 2, 1'b0, 1'b0, cyc);
    check_val("lw_stall_cycles", cyc, 10);
    check_val("lw_stall_ir_write_pulses", ir_cnt - base_a, 1);
    check_val("lw_stall_mdr_write_pulses", mdr_cnt - base_b, 1);

    // Other ALU functions through R_EXEC
    run_instr(6'h00, 6'h22, 0, 0, 1'b1, 1'b0, cyc);
    run_instr(6'h00, 6'h24, 1, 0, 1'b1, 1'b0, cyc);
    run_instr(6'h00, 6'h27, 0, 0, 1'b1, 1'b0, cyc);

    // Unsupported instructions
    base_a = ill_cnt; base_b = rw_cnt;
    run_instr(6'h00, 6'h2A, 0, 0, 1'b1, 1'b0, cyc);
    check_val("slt_cycles", cyc, 2);
    check_val("slt_illegal_pulses", ill_cnt - base_a, 1);
    check_val("slt_reg_writes", rw_cnt - base_b, 0);
    base_a = ill_cnt; base_b = rw_cnt;
    run_instr(6'h3F, 6'h20, 0, 0, 1'b1, 1'b0, cyc);
    check_val("op3f_illegal_pulses", ill_cnt - base_a, 1);
    check_val("op3f_reg_writes", rw_cnt - base_b, 0);

    // ori: executes when the immediate path is built in, otherwise illegal
    base_a = ill_cnt; base_b = rw_cnt;
    run_instr(6'h0D, 6'h00, 0, 0, 1'b1, 1'b0, cyc);
    check_val("ori_cycles", cyc, IMM_EN ? 4 : 2);
    check_val("ori_illegal_pulses", ill_cnt - base_a, IMM_EN ? 0 : 1);
    check_val("ori_reg_writes", rw_cnt - base_b, IMM_EN ? 1 : 0);
    run_instr(6'h08, 6'h00, 0, 0, 1'b1, 1'b0, cyc);
    run_instr(6'h0E, 6'h00, 0, 0, 1'b1, 1'b0, cyc);

    // Reset dropped mid-store while memory is stalled
    drive_cycle(6'h2B, 6'h00, 1'b1, 1'b1, 0);
    drive_cycle(6'h2B, 6'h00, 1'b1, 1'b1, 1);
    drive_cycle(6'h2B, 6'h00, 1'b1, 1'b1, 2);
    drive_cycle(6'h2B, 6'h00, 1'b0, 1'b1, 5);
    #3;
    check_val("memwr_before_reset", int'(mem_write), 1);
    rst_n = 1'b0;
    #1;
    check_val("memwr_async_reset", int'(mem_write), 0);
    check_val("state_async_reset", int'(state), 15);
    drive_cycle(6'h2B, 6'h00, 1'b0, 1'b0, 15);
    drive_cycle(6'h00, 6'h25, 1'b1, 1'b1, 15);
    run_instr(6'h00, 6'h25, 0, 0, 1'b1, 1'b0, cyc);

    @(negedge clk);
    #4;
    check_val("model_queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle main control unit for the CPU datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath enable and mux select. It sits directly upstream of the ALU and supplies its 6-bit `alu_op` using the ALU's funct-style encoding. Memory accesses are handshaked with `mem_ready`.

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `opcode` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `mem_ready` in 1: memory completes the current read or write this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if ALU `Zero`. The datapath forms `pc_en = pc_write | (pc_write_cond & Zero)`.
- `iord` out 1: memory address source. 0 = PC, 1 = ALUOut.
- `mem_read` out 1; `mem_write` out 1.
- `ir_write` out 1; `mdr_write` out 1.
- `reg_dst` out 1: write-register select. 0 = rt, 1 = rd.
- `mem_to_reg` out 1: write-data select. 0 = ALUOut, 1 = MDR.
- `reg_write` out 1.
- `alu_src_a` out 1: ALU A select. 0 = PC, 1 = A register.
- `alu_src_b` out 2: ALU B select. 00 = B, 01 = 4, 10 = ext(imm), 11 = sext(imm)<<2.
- `imm_zext` out 1: zero-extend the immediate instead of sign-extending.
- `pc_source` out 2: PC source. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_op` out 6: ALU operation. NOP = 0x00, ADD = 0x20, SUB = 0x22, AND = 0x24, OR = 0x25, XOR = 0x26, NOR = 0x27.
- `illegal` out 1: one-cycle pulse when an unsupported instruction is decoded.
- `state` out 4: current state, for debug.

## Operation
The block is a Moore FSM. Outputs decode combinationally from the state register. Exceptions: `ir_write`, FETCH `pc_write` and `mdr_write` are additionally ANDed with `mem_ready`. Any output not listed for a state is 0, and `alu_op` defaults to NOP.

States and the outputs each one asserts:
- RESET (0xF): all outputs 0. Goes to FETCH on the first clock after `rst_n` rises.
- FETCH (0): `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=ADD, `pc_source`=00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Stays in FETCH while `mem_ready`=0, otherwise goes to DECODE.
- DECODE (1): `alu_src_a`=0, `alu_src_b`=11, `alu_op`=ADD (precomputes the branch target). Dispatch on `opcode`:
  - 0x00 → R_EXEC if `funct` ∈ {0x20, 0x22, 0x24..0x27}, else illegal.
  - 0x23 / 0x2B → MEM_ADDR.
  - 0x04 → BRANCH.
  - 0x02 → JUMP.
  - 0x08 / 0x0C / 0x0D / 0x0E → I_EXEC (see Configuration).
  - Anything else → illegal: pulse `illegal`, go to FETCH.
- MEM_ADDR (2): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=ADD. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD (3): `mem_read`=1, `iord`=1, `mdr_write`=`mem_ready`. Waits for `mem_ready`, then goes to MEM_WB.
- MEM_WB (4): `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Goes to FETCH.
- MEM_WR (5): `mem_write`=1, `iord`=1. Held until `mem_ready`, then goes to FETCH.
- R_EXEC (6): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=`funct`. Goes to R_WB.
- R_WB (7): `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Goes to FETCH.
- BRANCH (8): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=SUB, `pc_write_cond`=1, `pc_source`=01. Goes to FETCH.
- JUMP (9): `pc_write`=1, `pc_source`=10. Goes to FETCH.
- I_EXEC (10): `alu_src_a`=1, `alu_src_b`=10. Goes to I_WB.
  - `alu_op`: ADD for 0x08, AND for 0x0C, OR for 0x0D, XOR for 0x0E.
  - `imm_zext`=1 for 0x0C / 0x0D / 0x0E.
- I_WB (11): `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Goes to FETCH.

Any unused state code goes to FETCH with no outputs asserted.

## Timing
- Reset: asserting `rst_n` low forces RESET immediately (asynchronous), so all outputs are 0 during reset. This holds mid-instruction too; a pending memory access is abandoned.
- After release, FETCH is entered on the first rising edge.
- Cycles per instruction with `mem_ready` tied to 1:
  - R-type 4, lw 5, sw 4, beq 3, j 3, I-type ALU 4.
- Each cycle `mem_ready` is low in FETCH, MEM_RD or MEM_WR adds one cycle. All outputs hold steady during the wait.
- `mem_ready` has no effect in any other state.
- `illegal` is high for exactly the one DECODE cycle.
- `opcode` and `funct` must be stable from DECODE through the end of the instruction; the IR is only written in FETCH.

## Configuration
- `MC_CTRL_IMM_EN` defined: opcodes 0x08 / 0x0C / 0x0D / 0x0E decode to I_EXEC → I_WB as above.
- Not defined: those opcodes take the illegal path (`illegal` pulse, back to FETCH). States I_EXEC and I_WB are not generated, and `imm_zext` is tied to 0.

## Test plan
- Reset with `rst_n`=0 for 3 cycles, then release, `mem_ready`=1 → all outputs 0 during reset; `state` goes 0xF → 0 → 1. In FETCH, `ir_write` = `pc_write` = 1 and `alu_op` = 0x20.
- Sequence `add`, `sw`, `lw`, `beq`, `j` with `mem_ready`=1 → `state` traces:
  - add: 0, 1, 6, 7.
  - sw: 0, 1, 2, 5.
  - lw: 0, 1, 2, 3, 4.
  - beq: 0, 1, 8.
  - j: 0, 1, 9.
  - Also check `alu_op` 0x20 in R_EXEC, 0x22 in BRANCH, and `pc_write_cond`=1 only in BRANCH.
- `mem_ready` low 3 cycles in FETCH and 2 cycles in MEM_RD of a `lw` → lw takes 10 cycles total. `ir_write` and `mdr_write` each pulse exactly once, on the `mem_ready` cycle.
- R-type with `funct` 0x2A, and `opcode` 0x3F → one-cycle `illegal` pulse in DECODE, then FETCH. No `reg_write` is issued.
- `ori` (opcode 0x0D) with the macro defined → `state` 10 shows `alu_op`=0x25 and `imm_zext`=1, then state 11 shows `reg_write`=1. With the macro undefined → `illegal` pulses instead.
- Drop `rst_n` in MEM_WR while `mem_ready`=0 → `mem_write` falls to 0 immediately (asynchronously). After release the FSM restarts at FETCH.
